step_dir_decoder: RTL and testbench

- Receiving end of the step/dir pulse interface produced by the printer motion generator. One instance per axis.
- Synchronises and deglitches the incoming step and direction lines, then tracks a signed axis position.
- Measures the step period and flags direction-setup and travel-limit violations.
- Feeds position/speed back to the control logic and to the debug/display path.

---
 rtl/printer_pkg.sv | 16 +
 rtl/step_dir_filter.sv | 54 +++++
 rtl/step_dir_decoder.sv | 143 ++++++++++++++
 tb/tb_step_dir_decoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/printer_pkg.sv
// Shared printer motion types: decoder state, default timing
// constants and the signed axis position type.
package printer_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } dec_state_e;

  localparam int MIN_PULSE_DEF = 4;
  localparam int TIMEOUT_DEF   = 200000;
  localparam int POS_W         = 16;

  typedef logic signed [POS_W-1:0] pos_t;

endpackage

// File: rtl/step_dir_filter.sv
// One step/dir line: 2-FF synchroniser followed by a
// MIN_PULSE stable-cycle deglitch filter.
module step_dir_filter #(
  parameter int MIN_PULSE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic lvl,
  output logic chg
);

  localparam int CW = (MIN_PULSE < 2) ? 1 : $clog2(MIN_PULSE);
  localparam logic [CW-1:0] LAST = CW'(MIN_PULSE - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // chg fires on the edge where lvl takes the new value
  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    lvl_d   = lvl_q;
    cnt_d   = '0;
    chg     = 1'b0;
    if (sync2_q != lvl_q) begin
      if (cnt_q == LAST) begin
        lvl_d = sync2_q;
        chg   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lvl = lvl_q;

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: filters the lines, tracks a clamped
// signed position, measures step period and flags errors.
module step_dir_decoder
  import printer_pkg::*;
#(
  parameter int pWIDTH    = 20,
  parameter int POS_WIDTH = 16,
  parameter int MIN_PULSE = MIN_PULSE_DEF,
  parameter int POS_MAX   = 32767,
  parameter int POS_MIN   = -32768,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        step_in,
  input  logic                        dir_in,
  input  logic                        clr,
  input  logic                        load,
  input  logic signed [POS_WIDTH-1:0] load_val,
  output logic signed [POS_WIDTH-1:0] position,
  output logic                        step_evt,
  output logic [pWIDTH-1:0]           period_out,
  output logic                        period_valid,
  output logic                        moving,
  output logic                        limit_err,
  output logic                        dir_err
);

  localparam logic signed [POS_WIDTH-1:0] PMAX = POS_WIDTH'(POS_MAX);
  localparam logic signed [POS_WIDTH-1:0] PMIN = POS_WIDTH'(POS_MIN);
  localparam logic signed [POS_WIDTH-1:0] PONE = POS_WIDTH'(1);
  localparam logic [pWIDTH-1:0] ONES = '1;
  localparam logic [pWIDTH-1:0] CONE = pWIDTH'(1);
  localparam logic [pWIDTH-1:0] TO   = pWIDTH'(TIMEOUT);

  logic step_lvl, step_chg;
  logic dir_lvl, dir_chg;
  logic accept;

  dec_state_e                  state_q, state_d;
  logic [pWIDTH-1:0]           cnt_q, cnt_d;
  logic [pWIDTH-1:0]           period_q, period_d;
  logic signed [POS_WIDTH-1:0] pos_q, pos_d;
  logic                        evt_q, evt_d;
  logic                        pv_q, pv_d;
  logic                        lim_q, lim_d;
  logic                        derr_q, derr_d;

  step_dir_filter #(.MIN_PULSE(MIN_PULSE)) u_step (
    .clk (clk),
    .rst (rst),
    .din (step_in),
    .lvl (step_lvl),
    .chg (step_chg)
  );

  step_dir_filter #(.MIN_PULSE(MIN_PULSE)) u_dir (
    .clk (clk),
    .rst (rst),
    .din (dir_in),
    .lvl (dir_lvl),
    .chg (dir_chg)
  );

  assign accept = step_chg & ~step_lvl;

  always_comb begin
    state_d  = state_q;
    cnt_d    = (cnt_q == ONES) ? cnt_q : cnt_q + CONE;
    period_d = period_q;
    pos_d    = pos_q;
    evt_d    = 1'b0;
    pv_d     = 1'b0;
    lim_d    = lim_q;
    derr_d   = derr_q | (dir_chg & step_lvl);
    if (clr) begin
      state_d  = IDLE;
      cnt_d    = '0;
      period_d = '0;
      pos_d    = '0;
      lim_d    = 1'b0;
      derr_d   = 1'b0;
    end else begin
      if (accept) begin
        evt_d   = 1'b1;
        cnt_d   = '0;
        state_d = ACTIVE;
        if (state_q == ACTIVE) begin
          period_d = (cnt_q == ONES) ? ONES : cnt_q + CONE;
          pv_d     = 1'b1;
        end
        if (!load) begin
          if (dir_lvl) begin
            if (pos_q == PMAX) lim_d = 1'b1;
            else               pos_d = pos_q + PONE;
          end else begin
            if (pos_q == PMIN) lim_d = 1'b1;
            else               pos_d = pos_q - PONE;
          end
        end
      end else if (state_q == ACTIVE && cnt_q >= TO) begin
        state_d  = IDLE;
        period_d = ONES;
      end
      if (load) begin
        if (load_val > PMAX)      pos_d = PMAX;
        else if (load_val < PMIN) pos_d = PMIN;
        else                      pos_d = load_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pos_q    <= '0;
      evt_q    <= 1'b0;
      pv_q     <= 1'b0;
      lim_q    <= 1'b0;
      derr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pos_q    <= pos_d;
      evt_q    <= evt_d;
      pv_q     <= pv_d;
      lim_q    <= lim_d;
      derr_q   <= derr_d;
    end
  end

  assign position     = pos_q;
  assign step_evt     = evt_q;
  assign period_out   = period_q;
  assign period_valid = pv_q;
  assign moving       = (state_q == ACTIVE);
  assign limit_err    = lim_q;
  assign dir_err      = derr_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Bench for step_dir_decoder: vector table, corner-case
// sequences and a randomized run against a pulse-level model.
module tb_step_dir_decoder;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               step_in = 1'b0;
  logic               dir_in = 1'b0;
  logic               clr = 1'b0;
  logic               load = 1'b0;
  logic signed [15:0] load_val = '0;
  logic signed [15:0] position;
  logic               step_evt;
  logic [19:0]        period_out;
  logic               period_valid;
  logic               moving;
  logic               limit_err;
  logic               dir_err;

  step_dir_decoder #(
    .pWIDTH    (20),
    .POS_WIDTH (16),
    .MIN_PULSE (4),
    .POS_MAX   (7),
    .POS_MIN   (-8),
    .TIMEOUT   (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .step_in      (step_in),
    .dir_in       (dir_in),
    .clr          (clr),
    .load         (load),
    .load_val     (load_val),
    .position     (position),
    .step_evt     (step_evt),
    .period_out   (period_out),
    .period_valid (period_valid),
    .moving       (moving),
    .limit_err    (limit_err),
    .dir_err      (dir_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          evt_n, evt_at, pv_n, idle_pv;
  logic [19:0] pv_val;
  logic signed [15:0] evt_pos;

  typedef struct {
    int hi;
    int lo;
    int evt;
    int pos;
    int lim;
    int pv;
    int per;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  // one step pulse: hi cycles high then lo low, inputs at negedge
  task automatic pulse(input int hi, input int lo, input int dflip,
                       input int ld_at, input logic signed [15:0] lv);
    evt_n  = 0;
    evt_at = 0;
    pv_n   = 0;
    pv_val = '0;
    evt_pos = '0;
    for (int i = 1; i <= hi + lo; i++) begin
      @(negedge clk);
      step_in = (i <= hi);
      if (dflip != 0 && i == dflip) dir_in = ~dir_in;
      load     = (i == ld_at);
      load_val = lv;
      @(posedge clk);
      #1;
      if (step_evt) begin
        evt_n++;
        evt_at  = i;
        evt_pos = position;
      end
      if (period_valid) begin
        pv_n++;
        pv_val = period_out;
      end
    end
  endtask

  task automatic set_dir(input logic d);
    @(negedge clk);
    step_in = 1'b0;
    dir_in  = d;
    repeat (10) @(negedge clk);
  endtask

  task automatic idle(input int n);
    idle_pv = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (period_valid) idle_pv++;
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic do_load(input logic signed [15:0] v);
    @(negedge clk);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int pos_m;
    int lim_m;
    int h, l, d;

    for (int i = 0; i < 12; i++) begin
      tbl[i].hi  = 8;
      tbl[i].lo  = 8;
      tbl[i].evt = 1;
      tbl[i].pos = (i < 7) ? i + 1 : 7;
      tbl[i].lim = (i >= 7) ? 1 : 0;
      tbl[i].pv  = (i == 0) ? 0 : 1;
      tbl[i].per = 16;
    end
    tbl[10] = '{hi: 3, lo: 8, evt: 0, pos: 7, lim: 1, pv: 0, per: 0};
    tbl[11] = '{hi: 4, lo: 8, evt: 1, pos: 7, lim: 1, pv: 1, per: 27};

    // reset held with a toggling step line
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      step_in = ~step_in;
      @(posedge clk);
      #1;
      chk("rst_out", {position, step_evt, period_out, period_valid,
                      moving, limit_err, dir_err}, 0);
    end
    @(negedge clk);
    rst     = 1'b1;
    step_in = 1'b0;
    evt_n   = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (step_evt) evt_n++;
    end
    chk("rst_noevt", evt_n, 0);

    // count up to the limit, then glitch rejection
    set_dir(1'b1);
    for (int i = 0; i < 12; i++) begin
      pulse(tbl[i].hi, tbl[i].lo, 0, 0, 0);
      chk($sformatf("v%0d_evt", i), evt_n, tbl[i].evt);
      if (tbl[i].evt != 0) chk($sformatf("v%0d_lat", i), evt_at, 6);
      chk($sformatf("v%0d_pos", i), $signed(position), tbl[i].pos);
      chk($sformatf("v%0d_lim", i), limit_err, tbl[i].lim);
      chk($sformatf("v%0d_pv", i), pv_n, tbl[i].pv);
      if (tbl[i].pv != 0) chk($sformatf("v%0d_per", i), pv_val, tbl[i].per);
    end
    chk("cu_moving", moving, 1);

    // dir change while step is high
    do_clr();
    set_dir(1'b0);
    pulse(8, 12, 3, 0, 0);
    chk("ds_pos", $signed(position), -1);
    chk("ds_derr", dir_err, 1);
    do_clr();
    @(posedge clk);
    #1;
    chk("clr_pos", $signed(position), 0);
    chk("clr_derr", dir_err, 0);
    chk("clr_lim", limit_err, 0);
    chk("clr_per", period_out, 0);
    chk("clr_mov", moving, 0);

    // timeout back to idle
    pulse(8, 8, 0, 0, 0);
    chk("to_evt", evt_n, 1);
    chk("to_pv0", pv_n, 0);
    chk("to_mov1", moving, 1);
    idle(110);
    chk("to_idle_pv", idle_pv, 0);
    chk("to_mov0", moving, 0);
    chk("to_per", period_out, 20'hFFFFF);
    pulse(8, 8, 0, 0, 0);
    chk("to_first_pv", pv_n, 0);
    pulse(8, 8, 0, 0, 0);
    chk("to_second_pv", pv_n, 1);
    chk("to_second_per", pv_val, 16);
    chk("to_pos", $signed(position), 3);

    // load coinciding with an accepted step
    pulse(8, 8, 0, 6, 16'sd5);
    chk("col_evt", evt_n, 1);
    chk("col_evtpos", $signed(evt_pos), 5);
    chk("col_pos", $signed(position), 5);
    chk("col_pv", pv_n, 1);
    do_load(16'sd20);
    chk("ld_hi", $signed(position), 7);
    do_load(-16'sd20);
    chk("ld_lo", $signed(position), -8);
    do_load(-16'sd3);
    chk("ld_mid", $signed(position), -3);

    // randomized pulse trains against a pulse-level model
    do_clr();
    pos_m = 0;
    lim_m = 0;
    for (int n = 0; n < 40; n++) begin
      h = $urandom_range(1, 12);
      l = $urandom_range(8, 20);
      d = $urandom_range(0, 1);
      if (d[0] != dir_in) set_dir(d[0]);
      pulse(h, l, 0, 0, 0);
      if (h >= 4) begin
        if (d == 1) begin
          if (pos_m == 7) lim_m = 1;
          else pos_m++;
        end else begin
          if (pos_m == -8) lim_m = 1;
          else pos_m--;
        end
      end
      chk($sformatf("r%0d_evt", n), evt_n, (h >= 4) ? 1 : 0);
      chk($sformatf("r%0d_pos", n), $signed(position), pos_m);
      chk($sformatf("r%0d_lim", n), limit_err, lim_m);
    end
    chk("r_derr", dir_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
